// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin write-back arbiter with a destination scoreboard.
// Define RFARB_BYPASS_EN so the write issued this cycle already hides its register from srN_busy.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_dr,
  input  logic [DATA_W-1:0]      a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_dr,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   b_ready,
  output logic                   ld_reg,
  output logic [ADDR_W-1:0]      wr_dr,
  output logic [DATA_W-1:0]      wr_data,
  input  logic                   claim_valid,
  input  logic [ADDR_W-1:0]      claim_dr,
  input  logic [ADDR_W-1:0]      sr1,
  input  logic [ADDR_W-1:0]      sr2,
  output logic                   sr1_busy,
  output logic                   sr2_busy,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic                   claim_err
);

  localparam int NREG = 1 << ADDR_W;

  // prio_b_q high means A won most recently, so B wins the next tie
  logic              prio_b_q, prio_b_d;
  logic              ld_reg_q, ld_reg_d;
  logic [ADDR_W-1:0] wr_dr_q, wr_dr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              claim_err_q, claim_err_d;

  logic              a_xfer, b_xfer;
  logic [NREG-1:0]   clr_vec, set_vec;

  always_comb begin
    a_ready = reset_n & a_valid & (~b_valid | ~prio_b_q);
    b_ready = reset_n & b_valid & (~a_valid |  prio_b_q);
    a_xfer  = a_valid & a_ready;
    b_xfer  = b_valid & b_ready;
  end

  always_comb begin
    prio_b_d  = prio_b_q;
    ld_reg_d  = a_xfer | b_xfer;
    wr_dr_d   = wr_dr_q;
    wr_data_d = wr_data_q;
    if (a_xfer) begin
      prio_b_d  = 1'b1;
      wr_dr_d   = a_dr;
      wr_data_d = a_data;
    end else if (b_xfer) begin
      prio_b_d  = 1'b0;
      wr_dr_d   = b_dr;
      wr_data_d = b_data;
    end
  end

  // A claim landing on the register being cleared wins, and is not an error
  always_comb begin
    clr_vec     = ld_reg_q ? ({{(NREG-1){1'b0}}, 1'b1} << wr_dr_q) : '0;
    set_vec     = claim_valid ? ({{(NREG-1){1'b0}}, 1'b1} << claim_dr) : '0;
    pending_d   = (pending_q & ~clr_vec) | set_vec;
    claim_err_d = claim_err_q |
                  (claim_valid & pending_q[claim_dr] & ~clr_vec[claim_dr]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_b_q    <= 1'b0;
      ld_reg_q    <= 1'b0;
      wr_dr_q     <= '0;
      wr_data_q   <= '0;
      pending_q   <= '0;
      claim_err_q <= 1'b0;
    end else begin
      prio_b_q    <= prio_b_d;
      ld_reg_q    <= ld_reg_d;
      wr_dr_q     <= wr_dr_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
      claim_err_q <= claim_err_d;
    end
  end

  always_comb begin
`ifdef RFARB_BYPASS_EN
    sr1_busy = pending_q[sr1] & ~(ld_reg_q & (wr_dr_q == sr1));
    sr2_busy = pending_q[sr2] & ~(ld_reg_q & (wr_dr_q == sr2));
`else
    sr1_busy = pending_q[sr1];
    sr2_busy = pending_q[sr2];
`endif
  end

  assign ld_reg    = ld_reg_q;
  assign wr_dr     = wr_dr_q;
  assign wr_data   = wr_data_q;
  assign pending   = pending_q;
  assign claim_err = claim_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;

  logic        clock, reset_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [2:0]  a_dr, b_dr, wr_dr, claim_dr, sr1, sr2;
  logic [15:0] a_data, b_data, wr_data;
  logic        ld_reg, claim_valid, sr1_busy, sr2_busy, claim_err;
  logic [7:0]  pending;

  int total = 0;
  int bad   = 0;

  // model: who won last (0=A, 1=B), scoreboard bits, pending write-port contents
  int        last_won;
  bit [7:0]  m_pend;
  bit        m_err, m_ld;
  bit [2:0]  m_dr;
  bit [15:0] m_data;

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_dr(a_dr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dr(b_dr), .b_data(b_data), .b_ready(b_ready),
    .ld_reg(ld_reg), .wr_dr(wr_dr), .wr_data(wr_data),
    .claim_valid(claim_valid), .claim_dr(claim_dr),
    .sr1(sr1), .sr2(sr2), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
    .pending(pending), .claim_err(claim_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_busy(input bit [2:0] s);
`ifdef RFARB_BYPASS_EN
    return m_pend[s] && !(m_ld && m_dr == s);
`else
    return m_pend[s];
`endif
  endfunction

  task automatic model_reset();
    last_won = 1;
    m_pend   = '0;
    m_err    = 1'b0;
    m_ld     = 1'b0;
    m_dr     = '0;
    m_data   = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".ld_reg"},    32'(ld_reg),    32'(m_ld));
    check({tag, ".wr_dr"},     32'(wr_dr),     32'(m_dr));
    check({tag, ".wr_data"},   32'(wr_data),   32'(m_data));
    check({tag, ".pending"},   32'(pending),   32'(m_pend));
    check({tag, ".claim_err"}, 32'(claim_err), 32'(m_err));
  endtask

  // One cycle: drive, check combinational outputs, clock, check registered outputs
  task automatic step(input string tag,
                      input bit av, input bit [2:0] adr, input bit [15:0] ad,
                      input bit bv, input bit [2:0] bdr, input bit [15:0] bd,
                      input bit cv, input bit [2:0] cdr,
                      input bit [2:0] s1, input bit [2:0] s2);
    bit ea, eb;
    a_valid = av; a_dr = adr; a_data = ad;
    b_valid = bv; b_dr = bdr; b_data = bd;
    claim_valid = cv; claim_dr = cdr;
    sr1 = s1; sr2 = s2;
    #1;
    if (av && bv) begin
      ea = (last_won == 1);
      eb = !ea;
    end else begin
      ea = av;
      eb = bv;
    end
    check({tag, ".a_ready"},  32'(a_ready),  32'(ea));
    check({tag, ".b_ready"},  32'(b_ready),  32'(eb));
    check({tag, ".sr1_busy"}, 32'(sr1_busy), 32'(exp_busy(s1)));
    check({tag, ".sr2_busy"}, 32'(sr2_busy), 32'(exp_busy(s2)));
    @(posedge clock);
    if (cv && m_pend[cdr] && !(m_ld && m_dr == cdr)) m_err = 1'b1;
    if (m_ld) m_pend[m_dr] = 1'b0;
    if (cv) m_pend[cdr] = 1'b1;
    if (ea) begin
      m_ld = 1'b1; m_dr = adr; m_data = ad; last_won = 0;
    end else if (eb) begin
      m_ld = 1'b1; m_dr = bdr; m_data = bd; last_won = 1;
    end else begin
      m_ld = 1'b0;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag, input bit [2:0] s1);
    step(tag, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, s1, 3'd0);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; claim_valid = 1'b0;
    a_dr = 3'd1; b_dr = 3'd2; a_data = 16'h1111; b_data = 16'h2222;
    claim_dr = '0; sr1 = '0; sr2 = '0;
    #1;
    check("rst.a_ready", 32'(a_ready), 32'd0);
    check("rst.b_ready", 32'(b_ready), 32'd0);
    check_regs("rst");
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // alternating grants under continuous dual requests
    for (int i = 0; i < 4; i++)
      step("rr", 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 0, 0, 3'd1, 3'd2);
    check("rr.last_dr", 32'(wr_dr), 32'd2);

    // claim R3, write it back from B two cycles later
    step("c3.claim", 0, 0, 16'h0, 0, 0, 16'h0, 1, 3'd3, 3'd3, 3'd0);
    idle("c3.wait1", 3'd3);
    idle("c3.wait2", 3'd3);
    step("c3.wb", 0, 0, 16'h0, 1, 3'd3, 16'hBEEF, 0, 0, 3'd3, 3'd0);
    check("c3.data", 32'(wr_data), 32'hBEEF);
    idle("c3.ldcyc", 3'd3);
    check("c3.cleared", 32'(pending[3]), 32'd0);

    // claim collides with the clear of the same register
    step("c4.claim", 0, 0, 16'h0, 0, 0, 16'h0, 1, 3'd4, 3'd4, 3'd0);
    step("c4.wb", 1, 3'd4, 16'h4444, 0, 0, 16'h0, 0, 0, 3'd4, 3'd0);
    step("c4.reclaim", 0, 0, 16'h0, 0, 0, 16'h0, 1, 3'd4, 3'd4, 3'd0);
    check("c4.pend", 32'(pending[4]), 32'd1);
    check("c4.err", 32'(claim_err), 32'd0);
    step("c4.wb2", 0, 0, 16'h0, 1, 3'd4, 16'h4545, 0, 0, 3'd4, 3'd0);
    idle("c4.drain", 3'd4);

    // double claim of R5 sets the sticky error
    step("c5.claim1", 0, 0, 16'h0, 0, 0, 16'h0, 1, 3'd5, 3'd5, 3'd0);
    step("c5.claim2", 0, 0, 16'h0, 0, 0, 16'h0, 1, 3'd5, 3'd5, 3'd0);
    check("c5.err", 32'(claim_err), 32'd1);
    step("c5.wb", 1, 3'd5, 16'h5555, 0, 0, 16'h0, 0, 0, 3'd5, 3'd0);
    idle("c5.drain", 3'd5);
    check("c5.pend", 32'(pending[5]), 32'd0);
    check("c5.err_held", 32'(claim_err), 32'd1);

    // reset during an ld_reg cycle
    step("mr.claim", 0, 0, 16'h0, 0, 0, 16'h0, 1, 3'd6, 3'd6, 3'd0);
    step("mr.wb", 1, 3'd6, 16'h6666, 0, 0, 16'h0, 0, 0, 3'd6, 3'd0);
    check("mr.ld_before", 32'(ld_reg), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_regs("mr");
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    idle("mr.idle", 3'd6);
    step("mr.dual", 1, 3'd1, 16'hA0A0, 1, 3'd2, 16'hB0B0, 0, 0, 3'd1, 3'd2);
    check("mr.grantA", 32'(wr_dr), 32'd1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step("rnd",
           1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
           ($urandom_range(0, 2) == 0), 3'($urandom),
           3'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, giving the register index width (2**ADDR_W registers).
Ports:
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have ports a_valid, input, 1; a_dr, input, ADDR_W; a_data, input, DATA_W; a_ready, output, 1: the ALU write-back requester.
REQ-006 The block SHALL have ports b_valid, input, 1; b_dr, input, ADDR_W; b_data, input, DATA_W; b_ready, output, 1: the memory-load write-back requester.
REQ-007 The block SHALL have ports ld_reg, output, 1; wr_dr, output, ADDR_W; wr_data, output, DATA_W: the register-file write port.
REQ-008 The block SHALL have ports claim_valid, input, 1, and claim_dr, input, ADDR_W: the issue stage marking a destination as pending.
REQ-009 The block SHALL have ports sr1 and sr2, input, ADDR_W each; sr1_busy and sr2_busy, output, 1 each: source-operand hazard flags.
REQ-010 The block SHALL have port pending, output, 2**ADDR_W, the scoreboard vector.
REQ-011 The block SHALL have port claim_err, output, 1, a sticky protocol-error flag.

Function
REQ-012 A transfer SHALL occur on a rising edge when x_valid and x_ready are both high; a_ready and b_ready SHALL never both be high.
REQ-013 x_ready SHALL be combinational from x_valid and the round-robin pointer only, with no dependency on the current cycle's x_ready.
REQ-014 If only one requester is valid, that requester SHALL be ready.
REQ-015 If both requesters are valid, the requester not granted most recently SHALL be ready, and the pointer SHALL move to the winner on the transfer.
REQ-016 On a transfer, ld_reg SHALL be high for exactly the next cycle, with wr_dr and wr_data holding the winner's dr and data (latency 1 cycle); otherwise ld_reg SHALL be 0 and wr_dr and wr_data SHALL hold their last values.
REQ-017 Back-to-back transfers SHALL produce ld_reg high on consecutive cycles (throughput 1 write per cycle).
REQ-018 A claim (claim_valid high at an edge) SHALL set pending[claim_dr].
REQ-019 pending[wr_dr] SHALL clear at the edge that ends a cycle in which ld_reg is high.
REQ-020 If a claim and a clear target the same register at the same edge, the bit SHALL end set.
REQ-021 A claim to a register whose pending bit is already set (and not clearing that edge) SHALL set claim_err, which SHALL remain set until reset.
REQ-022 A write-back to a non-pending register SHALL still be performed and SHALL NOT set claim_err.
REQ-023 sr1_busy SHALL equal pending[sr1], and sr2_busy SHALL equal pending[sr2], combinationally, subject to REQ-028.

Reset
REQ-024 While reset_n is low: a_ready, b_ready, ld_reg and claim_err SHALL be 0; wr_dr, wr_data and pending SHALL be all zeros; and the round-robin pointer SHALL favour requester A.
REQ-025 Reset assertion mid-operation SHALL drop any in-flight ld_reg pulse immediately, with no write issued after reset_n rises until a new transfer.
REQ-026 The first arbitration after reset SHALL grant A when both requesters are valid.

Configuration
REQ-027 Macro RFARB_BYPASS_EN SHALL select same-cycle bypass.
REQ-028 With RFARB_BYPASS_EN defined, srN_busy SHALL be pending[srN] AND NOT (ld_reg AND wr_dr == srN).
REQ-029 Without RFARB_BYPASS_EN, srN_busy SHALL be pending[srN] only; all other behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset, then a_valid=b_valid=1 held, a_dr=1/a_data=16'h1111, b_dr=2/b_data=16'h2222 -> grants A,B,A,B on successive edges; ld_reg high every cycle with wr_dr 1,2,1,2.
REQ-031 Claim R3, then 2 cycles later b_valid with b_dr=3 and b_data=16'hBEEF -> pending[3]=1 until the edge after the ld_reg cycle; wr_data=16'hBEEF; sr1=3 shows busy throughout (without macro).
REQ-032 With RFARB_BYPASS_EN: same as REQ-031 -> sr1_busy=0 during the ld_reg cycle for R3.
REQ-033 Claim R5 twice without an intervening write-back -> claim_err=1 and held; a subsequent write-back to R5 clears pending[5] while claim_err stays 1.
REQ-034 Claim R4 on the same edge that ld_reg clears R4 -> pending[4]=1 and claim_err=0.
REQ-035 Assert reset_n=0 during a cycle with ld_reg high -> ld_reg=0 immediately, pending=0, and the next dual request grants A.
